adbg_ahb3_arb: RTL and testbench

ADBG_AHB3_ARB -- requirements
Module: adbg_ahb3_arb

---
 rtl/adbg_ahb3_pkg.sv | 41 ++++
 rtl/adbg_ahb3_rr_arb.sv | 38 +++
 rtl/adbg_ahb3_arb.sv | 129 ++++++++++++
 tb/tb_adbg_ahb3_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_ahb3_pkg.sv
// Shared AHB3 encodings and the bus-master FSM state type for the debug
// AHB3 front end.
package adbg_ahb3_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HSIZE encodings (bytes per beat = 1 << HSIZE)
   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   // HBURST encodings
   localparam logic [3:0] HBURST_SINGLE = 4'b0000;
   localparam logic [3:0] HBURST_INCR   = 4'b0001;
   localparam logic [3:0] HBURST_WRAP4  = 4'b0010;
   localparam logic [3:0] HBURST_INCR4  = 4'b0011;

   // HPROT bit meanings; a cleared bit means opcode / user /
   // non-bufferable / non-cacheable respectively
   localparam logic [3:0] HPROT_DATA       = 4'b0001;
   localparam logic [3:0] HPROT_PRIVILEGED = 4'b0010;
   localparam logic [3:0] HPROT_BUFFERABLE = 4'b0100;
   localparam logic [3:0] HPROT_CACHEABLE  = 4'b1000;

   // Debug accesses are privileged data accesses that must reach the
   // target directly, never through a write buffer or cache
   localparam logic [3:0] HPROT_DEBUG = HPROT_DATA | HPROT_PRIVILEGED;

   // Bus-master FSM: one single transfer at a time
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for an eligible requester
      ST_ADDR = 2'd1,   // NONSEQ address phase on the bus
      ST_DATA = 2'd2    // data phase, waiting for HREADY
   } ahb_state_e;

endpackage : adbg_ahb3_pkg

// File: rtl/adbg_ahb3_rr_arb.sv
// Two-way round-robin grant. When both requests are present the
// requester not granted last wins; the history only moves on a grant.
module adbg_ahb3_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic       grant_valid,
   output logic       grant_idx
);

   // Index of the requester granted most recently. Reset to 1 so that
   // requester 0 wins the first contested grant.
   logic last_q;

   // Pick the winner among the current requests
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so no path through the case can leave it unassigned and infer a latch.
      grant_valid = |req;
      grant_idx   = 1'b0;
      unique case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_q;
         default: grant_idx = 1'b0;
      endcase
   end

   // Remember who won, only when a grant is actually issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (grant_valid) begin
         last_q <= grant_idx;
      end
   end

endmodule : adbg_ahb3_rr_arb

// File: rtl/adbg_ahb3_arb.sv
// AHB3 single-transfer bus master shared by two debug requesters.
// Each requester raises a level strobe with its transfer attributes and
// holds it until a one-cycle ack returns with read data and error status.
// DATA_WIDTH is meant to be 32 or 64.
module adbg_ahb3_arb
   import adbg_ahb3_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,

   // requester side
   input  logic [1:0]                 req_strb,
   input  logic [1:0]                 req_we,
   input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0][2:0]            req_size,
   input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]                 req_ack,
   output logic                       req_err,
   output logic [DATA_WIDTH-1:0]      req_rdata,

   // AHB3 master side
   output logic                       HSEL,
   output logic [ADDR_WIDTH-1:0]      HADDR,
   output logic [DATA_WIDTH-1:0]      HWDATA,
   output logic                       HWRITE,
   output logic [2:0]                 HSIZE,
   output logic [3:0]                 HBURST,
   output logic [3:0]                 HPROT,
   output logic [1:0]                 HTRANS,
   output logic                       HMASTLOCK,
   input  logic [DATA_WIDTH-1:0]      HRDATA,
   input  logic                       HREADY,
   input  logic                       HRESP
);

   ahb_state_e             state_q;
   ahb_state_e             state_d;
   logic [1:0]             eligible;
   logic                   grant_valid;
   logic                   grant_idx;
   logic                   owner_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic                   xfer_done;

   // Fixed single-transfer attributes
   assign HSEL      = 1'b1;
   assign HMASTLOCK = 1'b0;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_DEBUG;

   // Only IDLE arbitrates. A strobe whose ack is on the wire this cycle
   // is still high but already served, so it is masked out.
   assign eligible = (state_q == ST_IDLE) ? (req_strb & ~req_ack) : 2'b00;

   // The data phase completes on the first edge with HREADY high
   assign xfer_done = (state_q == ST_DATA) && HREADY;

   assign HTRANS = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HWDATA = wdata_q;

   adbg_ahb3_rr_arb u_rr_arb (
      .clk         (HCLK),
      .rst_n       (HRESETn),
      .req         (eligible),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // FSM state register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      // NOTE: state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      if (!HRESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: IDLE -> ADDR on grant, then advance on HREADY
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (grant_valid) state_d = ST_ADDR;
         ST_ADDR: if (HREADY)      state_d = ST_DATA;
         ST_DATA: if (HREADY)      state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Capture the winner's transfer attributes; held until the next grant
   always_ff @(posedge HCLK or negedge HRESETn) begin
      // NOTE: the bus-facing datapath registers are reset as well, so the
      // AHB outputs show known values while the block is held in reset.
      if (!HRESETn) begin
         HADDR   <= '0;
         HWRITE  <= 1'b0;
         HSIZE   <= 3'b000;
         wdata_q <= '0;
         owner_q <= 1'b0;
      end else if (grant_valid) begin
         HADDR   <= req_addr[grant_idx];
         HWRITE  <= req_we[grant_idx];
         HSIZE   <= req_size[grant_idx];
         wdata_q <= req_wdata[grant_idx];
         owner_q <= grant_idx;
      end
   end

   // Return the completed transfer's response and pulse the owner's ack
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         req_ack   <= 2'b00;
         req_err   <= 1'b0;
         req_rdata <= '0;
      end else begin
         req_ack <= 2'b00;
         if (xfer_done) begin
            req_ack[owner_q] <= 1'b1;
            req_err          <= HRESP;
            req_rdata        <= HRDATA;
         end
      end
   end

endmodule : adbg_ahb3_arb

// File: tb/tb_adbg_ahb3_arb.sv
// Self-checking bench for adbg_ahb3_arb: a transaction-level model predicts
// the bus and requester outputs every cycle, and directed scenarios pin
// hand-computed values.
module tb_adbg_ahb3_arb;

   logic             HCLK = 1'b0;
   logic             HRESETn = 1'b0;
   logic [1:0]       req_strb;
   logic [1:0]       req_we;
   logic [1:0][31:0] req_addr;
   logic [1:0][2:0]  req_size;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       req_ack;
   logic             req_err;
   logic [31:0]      req_rdata;
   logic             HSEL;
   logic [31:0]      HADDR;
   logic [31:0]      HWDATA;
   logic             HWRITE;
   logic [2:0]       HSIZE;
   logic [3:0]       HBURST;
   logic [3:0]       HPROT;
   logic [1:0]       HTRANS;
   logic             HMASTLOCK;
   logic [31:0]      HRDATA;
   logic             HREADY;
   logic             HRESP;

   adbg_ahb3_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .req_strb  (req_strb),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_wdata (req_wdata),
      .req_ack   (req_ack),
      .req_err   (req_err),
      .req_rdata (req_rdata),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HPROT     (HPROT),
      .HTRANS    (HTRANS),
      .HMASTLOCK (HMASTLOCK),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY),
      .HRESP     (HRESP)
   );

   always #5 HCLK = ~HCLK;

   int n_total = 0;
   int n_bad   = 0;
   int obs[$];            // requester index of every ack seen on the DUT
   logic [1:0] ack_seen = 2'b00;

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      int          owner;
      logic        we;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } txn_t;

   int          m_phase = 0;   // 0 none in flight, 1 address phase, 2 data phase
   int          m_last  = 1;   // last requester granted
   txn_t        m_txn   = '{0, 1'b0, 32'h0, 3'h0, 32'h0};
   logic [1:0]  m_ack   = 2'b00;
   logic        m_err   = 1'b0;
   logic [31:0] m_rdata = 32'h0;

   // Round-robin choice among the wanting requesters, -1 if none
   function automatic int pick(input logic [1:0] want, input int last);
      if (want == 2'b11) return 1 - last;
      if (want[0]) return 0;
      if (want[1]) return 1;
      return -1;
   endfunction

   function automatic txn_t snap(input int i);
      txn_t t;
      t.owner = i;
      t.we    = req_we[i];
      t.addr  = req_addr[i];
      t.size  = req_size[i];
      t.wdata = req_wdata[i];
      return t;
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m_phase <= 0;
         m_last  <= 1;
         m_txn   <= '{0, 1'b0, 32'h0, 3'h0, 32'h0};
         m_ack   <= 2'b00;
         m_err   <= 1'b0;
         m_rdata <= 32'h0;
      end else begin
         m_ack <= 2'b00;
         if (m_phase == 0) begin
            if (pick(req_strb & ~m_ack, m_last) >= 0) begin
               m_phase <= 1;
               m_last  <= pick(req_strb & ~m_ack, m_last);
               m_txn   <= snap(pick(req_strb & ~m_ack, m_last));
            end
         end else if (m_phase == 1) begin
            if (HREADY) m_phase <= 2;
         end else begin
            if (HREADY) begin
               m_phase              <= 0;
               m_ack[m_txn.owner[0]] <= 1'b1;
               m_rdata              <= HRDATA;
               m_err                <= HRESP;
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Compare every DUT output against the model for the current cycle
   task automatic cmp_cycle();
      check("m_htrans", {62'd0, HTRANS}, (m_phase == 1) ? 64'd2 : 64'd0);
      check("m_haddr",  {32'd0, HADDR},  {32'd0, m_txn.addr});
      check("m_hwrite", {63'd0, HWRITE}, {63'd0, m_txn.we});
      check("m_hsize",  {61'd0, HSIZE},  {61'd0, m_txn.size});
      check("m_ack",    {62'd0, req_ack}, {62'd0, m_ack});
      if (m_phase == 2 || !HRESETn)
         check("m_hwdata", {32'd0, HWDATA}, {32'd0, m_txn.wdata});
      if (m_ack != 2'b00 || !HRESETn) begin
         check("m_rdata", {32'd0, req_rdata}, {32'd0, m_rdata});
         check("m_err",   {63'd0, req_err},   {63'd0, m_err});
      end
      if (HRESETn && req_ack != 2'b00) obs.push_back(req_ack[1] ? 1 : 0);
   endtask

   // One clock: compare, then let requesters drop a strobe one cycle
   // after they saw their ack
   task automatic tick();
      @(negedge HCLK);
      cmp_cycle();
      for (int i = 0; i < 2; i++)
         if (ack_seen[i]) req_strb[i] = 1'b0;
      ack_seen = req_ack;
   endtask

   task automatic wait_ack(input int i, input int budget, input string name);
      logic got;
      got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         tick();
         if (req_ack[i]) got = 1'b1;
      end
      check(name, {63'd0, got}, 64'd1);
   endtask

   function automatic int obs_at(input int k);
      if (k < obs.size()) return obs[k];
      return 9;
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      int base;
      bit reraised;

      req_strb  = 2'b00;
      req_we    = 2'b00;
      req_addr  = '0;
      req_size  = '0;
      req_wdata = '0;
      HRDATA    = 32'h0;
      HREADY    = 1'b1;
      HRESP     = 1'b0;

      // reset values and tied-off attributes
      repeat (3) tick();
      check("rst_htrans", {62'd0, HTRANS}, 64'd0);
      check("rst_ack",    {62'd0, req_ack}, 64'd0);
      check("rst_haddr",  {32'd0, HADDR}, 64'd0);
      check("tie_hsel",   {63'd0, HSEL}, 64'd1);
      check("tie_lock",   {63'd0, HMASTLOCK}, 64'd0);
      check("tie_hburst", {60'd0, HBURST}, 64'd0);
      check("tie_hprot",  {60'd0, HPROT}, 64'h3);
      HRESETn = 1'b1;
      repeat (2) tick();

      // single read from requester 0, zero wait states
      req_we[0]   = 1'b0;
      req_addr[0] = 32'h100;
      req_size[0] = 3'd2;
      HRDATA      = 32'hDEADBEEF;
      req_strb[0] = 1'b1;
      tick();
      check("s1_nonseq", {62'd0, HTRANS}, 64'd2);
      check("s1_haddr",  {32'd0, HADDR}, 64'h100);
      tick();
      check("s1_data_idle", {62'd0, HTRANS}, 64'd0);
      check("s1_no_early_ack", {62'd0, req_ack}, 64'd0);
      tick();
      check("s1_ack",   {62'd0, req_ack}, 64'd1);
      check("s1_rdata", {32'd0, req_rdata}, 64'hDEADBEEF);
      check("s1_err",   {63'd0, req_err}, 64'd0);
      tick();   // strobe was still high at the edge ending the ack cycle
      check("s1_mask_htrans", {62'd0, HTRANS}, 64'd0);
      tick();
      check("s1_mask_ack", {62'd0, req_ack}, 64'd0);
      check("s1_mask_idle", {62'd0, HTRANS}, 64'd0);

      // both requesters raised from reset: 0, 1, 0
      HRESETn     = 1'b0;
      req_addr[0] = 32'h200;
      req_addr[1] = 32'h300;
      req_size[1] = 3'd2;
      req_we      = 2'b00;
      HRDATA      = 32'hA5A5A5A5;
      req_strb    = 2'b11;
      repeat (2) tick();
      HRESETn = 1'b1;
      base = obs.size();
      reraised = 1'b0;
      tick();
      check("s2_first_nonseq", {62'd0, HTRANS}, 64'd2);
      check("s2_first_addr", {32'd0, HADDR}, 64'h200);
      for (int k = 0; k < 40 && obs.size() < base + 3; k++) begin
         tick();
         if (!req_strb[0] && !reraised) begin
            req_strb[0] = 1'b1;
            reraised = 1'b1;
         end
      end
      tick();
      req_strb = 2'b00;
      check("s2_count",  obs.size() - base, 64'd3);
      check("s2_order0", obs_at(base),     64'd0);
      check("s2_order1", obs_at(base + 1), 64'd1);
      check("s2_order2", obs_at(base + 2), 64'd0);
      for (int k = base; k + 1 < obs.size(); k++)
         check("s2_alternate", {63'd0, obs[k] == obs[k + 1]}, 64'd0);
      repeat (2) tick();

      // requester 1 write with three wait states in the data phase
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'h20;
      req_size[1]  = 3'd2;
      req_wdata[1] = 32'h12345678;
      req_strb[1]  = 1'b1;
      tick();
      check("s3_nonseq", {62'd0, HTRANS}, 64'd2);
      check("s3_haddr",  {32'd0, HADDR}, 64'h20);
      check("s3_hwrite", {63'd0, HWRITE}, 64'd1);
      tick();
      HREADY = 1'b0;
      check("s3_hwdata0", {32'd0, HWDATA}, 64'h12345678);
      tick();
      check("s3_hwdata1", {32'd0, HWDATA}, 64'h12345678);
      check("s3_wait_ack1", {62'd0, req_ack}, 64'd0);
      tick();
      check("s3_hwdata2", {32'd0, HWDATA}, 64'h12345678);
      tick();
      HREADY = 1'b1;
      check("s3_hwdata3", {32'd0, HWDATA}, 64'h12345678);
      check("s3_wait_ack3", {62'd0, req_ack}, 64'd0);
      tick();
      check("s3_ack", {62'd0, req_ack}, 64'd2);
      repeat (2) tick();

      // two-cycle ERROR response, then another request proceeds
      req_we[0]   = 1'b0;
      req_addr[0] = 32'h40;
      HRDATA      = 32'h0BADF00D;
      req_strb[0] = 1'b1;
      tick();
      check("s4_nonseq", {62'd0, HTRANS}, 64'd2);
      tick();
      HREADY = 1'b0;
      HRESP  = 1'b1;
      tick();
      HREADY = 1'b1;
      check("s4_wait", {62'd0, req_ack}, 64'd0);
      tick();
      check("s4_ack",  {62'd0, req_ack}, 64'd1);
      check("s4_err",  {63'd0, req_err}, 64'd1);
      check("s4_idle", {62'd0, HTRANS}, 64'd0);
      HRESP       = 1'b0;
      req_we[1]   = 1'b0;
      req_addr[1] = 32'h44;
      HRDATA      = 32'h600DCAFE;
      req_strb[1] = 1'b1;
      tick();
      check("s4_next_nonseq", {62'd0, HTRANS}, 64'd2);
      check("s4_next_addr", {32'd0, HADDR}, 64'h44);
      wait_ack(1, 20, "s4_next_ack");
      check("s4_next_err",   {63'd0, req_err}, 64'd0);
      check("s4_next_rdata", {32'd0, req_rdata}, 64'h600DCAFE);
      repeat (2) tick();

      // reset in the middle of a data phase
      req_addr[0] = 32'h80;
      req_strb[0] = 1'b1;
      tick();
      tick();
      HREADY = 1'b0;
      tick();
      HRESETn = 1'b0;
      base = obs.size();
      tick();
      tick();
      check("s5_rst_htrans", {62'd0, HTRANS}, 64'd0);
      check("s5_rst_haddr",  {32'd0, HADDR}, 64'd0);
      check("s5_rst_hwdata", {32'd0, HWDATA}, 64'd0);
      check("s5_rst_rdata",  {32'd0, req_rdata}, 64'd0);
      check("s5_rst_err",    {63'd0, req_err}, 64'd0);
      req_addr[1] = 32'h90;
      req_strb    = 2'b11;
      HREADY      = 1'b1;
      HRESETn     = 1'b1;
      tick();
      check("s5_nonseq", {62'd0, HTRANS}, 64'd2);
      check("s5_req0_first", {32'd0, HADDR}, 64'h80);
      check("s5_no_ack", obs.size() - base, 64'd0);
      wait_ack(0, 20, "s5_ack0");
      wait_ack(1, 20, "s5_ack1");
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_adbg_ahb3_arb
